// File: rtl/cpu_trace_pkg.sv
// Shared types and constants for the CPU instruction trace buffer and its benches.
package cpu_trace_pkg;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  opcode;
    logic [7:0]  a;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  p;
    logic [7:0]  sp;
  } trace_rec_t;

  typedef enum logic [1:0] {
    TRIG_MANUAL  = 2'd0,
    TRIG_PC      = 2'd1,
    TRIG_HALT    = 2'd2,
    TRIG_PC_HALT = 2'd3
  } trig_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

  localparam logic [7:0] ST_READ_OPCODE = 8'd2;
  localparam logic [7:0] HALT_STATE     = 8'h7F;

endpackage

// File: rtl/trace_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
module trace_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned REC_W = 64
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [REC_W-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [REC_W-1:0]         o_rdata
);

  logic [REC_W-1:0] r_mem [DEPTH];
  logic [REC_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Circular opcode-fetch trace capture with programmable trigger, post-trigger depth
// and an oldest-first valid/ready drain.
module cpu_trace_buffer #(
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned REC_W      = 64,
  parameter logic [7:0]  HALT_STATE = 8'h7F,
  parameter int unsigned HALT_W     = 8
) (
  input  logic                     clkMaster,
  input  logic                     rst,
  input  logic                     rec_valid,
  input  logic [REC_W-1:0]         rec_data,
  input  logic [7:0]               cpu_state,
  input  logic                     arm,
  input  logic                     abort,
  input  logic                     trig_force,
  input  logic [1:0]               trig_mode,
  input  logic [15:0]              trig_pc,
  input  logic [HALT_W-1:0]        halt_cycles,
  input  logic [$clog2(DEPTH):0]   post_len,
  output logic                     out_valid,
  output logic [REC_W-1:0]         out_data,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     triggered,
  output logic                     overflow,
  output logic                     drain_done
);

  import cpu_trace_pkg::*;

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  trace_state_e      r_state;
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_post_rem;
  logic [CW-1:0]     r_issue_rem;
  logic [CW-1:0]     r_drain_left;
  logic              r_overflow;
  logic [HALT_W-1:0] r_halt_cnt;
  logic              r_pend;
  logic              r_out_valid;
  logic [REC_W-1:0]  r_out_data;
  logic              r_skid_valid;
  logic [REC_W-1:0]  r_skid_data;
  logic              r_drain_done;

  trig_mode_e        w_mode;
  logic              w_pc_en;
  logic              w_halt_en;
  logic [HALT_W-1:0] w_halt_run;
  logic              w_trig;
  logic              w_wr_en;
  logic [CW-1:0]     w_post_clamp;
  logic              w_pop;
  logic [1:0]        w_occ;
  logic              w_issue;
  logic [REC_W-1:0]  w_rdata;

  assign w_mode    = trig_mode_e'(trig_mode);
  assign w_pc_en   = (w_mode == TRIG_PC) || (w_mode == TRIG_PC_HALT);
  assign w_halt_en = (w_mode == TRIG_HALT) || (w_mode == TRIG_PC_HALT);

  // Includes the current cycle, so a threshold of N fires on the Nth halted cycle.
  assign w_halt_run = (cpu_state != HALT_STATE) ? '0 :
                      (&r_halt_cnt) ? r_halt_cnt : r_halt_cnt + HALT_W'(1);

  assign w_trig = (r_state == ARMED) && !abort &&
                  (trig_force ||
                   (w_pc_en && rec_valid && (rec_data[REC_W-1 -: 16] == trig_pc)) ||
                   (w_halt_en && (w_halt_run >= halt_cycles)));

  assign w_wr_en = rec_valid && !abort &&
                   ((r_state == ARMED) || ((r_state == POST) && (r_post_rem != '0)));

  assign w_post_clamp = (post_len > CW'(DEPTH)) ? CW'(DEPTH) : post_len;

  // Output register plus skid form a 2-entry queue; reads are issued only with a free slot.
  assign w_pop   = r_out_valid && out_ready;
  assign w_occ   = 2'(r_out_valid) + 2'(r_skid_valid) + 2'(r_pend);
  assign w_issue = (r_state == DONE) && !abort && (r_issue_rem != '0) &&
                   (w_occ <= (2'(w_pop) + 2'd1));

  trace_ram #(
    .DEPTH (DEPTH),
    .REC_W (REC_W)
  ) u_ram (
    .i_clk   (clkMaster),
    .i_we    (w_wr_en),
    .i_waddr (r_wr_ptr),
    .i_wdata (rec_data),
    .i_re    (w_issue),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clkMaster) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_post_rem   <= '0;
      r_issue_rem  <= '0;
      r_drain_left <= '0;
      r_overflow   <= 1'b0;
      r_halt_cnt   <= '0;
      r_pend       <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_drain_done <= 1'b0;
    end else begin
      r_halt_cnt   <= w_halt_run;
      r_drain_done <= 1'b0;
      r_pend       <= w_issue;

      if (w_issue) begin
        r_rd_ptr    <= r_rd_ptr + AW'(1);
        r_issue_rem <= r_issue_rem - CW'(1);
      end

      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        if (r_count == CW'(DEPTH)) begin
          r_overflow <= 1'b1;
        end else begin
          r_count <= r_count + CW'(1);
        end
      end

      if (w_pop) begin
        if (r_skid_valid) begin
          r_out_data   <= r_skid_data;
          r_skid_valid <= r_pend;
          r_skid_data  <= w_rdata;
        end else begin
          r_out_valid <= r_pend;
          r_out_data  <= w_rdata;
        end
      end else if (r_pend) begin
        if (!r_out_valid) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_rdata;
        end else begin
          r_skid_valid <= 1'b1;
          r_skid_data  <= w_rdata;
        end
      end

      unique case (r_state)
        IDLE: begin
          if (arm) begin
            r_state    <= ARMED;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
          end
        end
        ARMED: begin
          if (w_trig) begin
            r_state    <= POST;
            r_post_rem <= w_post_clamp;
          end
        end
        POST: begin
          if (r_post_rem == '0) begin
            r_state      <= DONE;
            r_rd_ptr     <= r_wr_ptr - r_count[AW-1:0];
            r_issue_rem  <= r_count;
            r_drain_left <= r_count;
          end else if (w_wr_en) begin
            r_post_rem <= r_post_rem - CW'(1);
          end
        end
        DONE: begin
          if ((r_drain_left == '0) || (w_pop && (r_drain_left == CW'(1)))) begin
            r_drain_done <= 1'b1;
            r_state      <= IDLE;
          end else if (w_pop) begin
            r_drain_left <= r_drain_left - CW'(1);
          end
        end
      endcase

      // Abort wins over every other transition; overflow is deliberately kept.
      if (abort) begin
        r_state      <= IDLE;
        r_issue_rem  <= '0;
        r_pend       <= 1'b0;
        r_out_valid  <= 1'b0;
        r_skid_valid <= 1'b0;
        r_drain_done <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = (r_state != IDLE);
  assign triggered  = (r_state == POST) || (r_state == DONE);
  assign overflow   = r_overflow;
  assign drain_done = r_drain_done;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed scoreboard bench for cpu_trace_buffer with an 8-entry buffer.
module tb_cpu_trace_buffer;

  import cpu_trace_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clkMaster;
  logic        rst;
  logic        rec_valid;
  logic [63:0] rec_data;
  logic [7:0]  cpu_state;
  logic        arm;
  logic        abort;
  logic        trig_force;
  logic [1:0]  trig_mode;
  logic [15:0] trig_pc;
  logic [7:0]  halt_cycles;
  logic [3:0]  post_len;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        triggered;
  logic        overflow;
  logic        drain_done;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb[$];

  cpu_trace_buffer #(
    .DEPTH      (DEPTH),
    .REC_W      (64),
    .HALT_STATE (HALT_STATE),
    .HALT_W     (8)
  ) dut (
    .clkMaster   (clkMaster),
    .rst         (rst),
    .rec_valid   (rec_valid),
    .rec_data    (rec_data),
    .cpu_state   (cpu_state),
    .arm         (arm),
    .abort       (abort),
    .trig_force  (trig_force),
    .trig_mode   (trig_mode),
    .trig_pc     (trig_pc),
    .halt_cycles (halt_cycles),
    .post_len    (post_len),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .triggered   (triggered),
    .overflow    (overflow),
    .drain_done  (drain_done)
  );

  initial clkMaster = 1'b0;
  always #5 clkMaster = ~clkMaster;

  initial begin
    #300000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mkrec(input logic [15:0] pc);
    trace_rec_t r;
    r.pc     = pc;
    r.opcode = pc[7:0] ^ 8'hA5;
    r.a      = pc[15:8];
    r.x      = pc[7:0] + 8'd1;
    r.y      = 8'h3C;
    r.p      = {4'h2, pc[3:0]};
    r.sp     = 8'hFD - pc[7:0];
    return r;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clkMaster);
  endtask

  task automatic send(input logic [15:0] pc, input bit push);
    rec_data  = mkrec(pc);
    rec_valid = 1'b1;
    if (push) sb.push_back(mkrec(pc));
    tick(1);
    rec_valid = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic pulse_force();
    trig_force = 1'b1;
    tick(1);
    trig_force = 1'b0;
  endtask

  // Drains with a repeating 4-cycle ready pattern, comparing each accepted record to the queue.
  task automatic drain(input string tag, input logic [3:0] pat);
    int          cyc = 0;
    bit          done_seen = 1'b0;
    logic        held_v = 1'b0;
    logic [63:0] held_d = '0;
    logic [63:0] exp;
    while (!done_seen && cyc < 200) begin
      out_ready = pat[cyc % 4];
      #1;
      if (held_v) begin
        chk({tag, "_hold_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_hold_data"}, out_data, held_d);
      end
      if (out_valid && out_ready) begin
        chk({tag, "_extra_record"}, 64'(sb.size() > 0), 64'(1));
        if (sb.size() > 0) begin
          exp = sb.pop_front();
          chk({tag, "_data"}, out_data, exp);
        end
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
      tick(1);
      if (drain_done) done_seen = 1'b1;
      cyc++;
    end
    out_ready = 1'b0;
    chk({tag, "_drain_done_seen"}, 64'(done_seen), 64'(1));
    chk({tag, "_all_streamed"}, 64'(sb.size()), 64'(0));
    chk({tag, "_idle_after"}, 64'(busy), 64'(0));
    chk({tag, "_valid_low_after"}, 64'(out_valid), 64'(0));
    sb.delete();
  endtask

  initial begin
    int   n;
    logic dd_seen;

    rst = 1'b1; rec_valid = 1'b0; rec_data = '0; cpu_state = ST_READ_OPCODE;
    arm = 1'b0; abort = 1'b0; trig_force = 1'b0; trig_mode = 2'd0; trig_pc = '0;
    halt_cycles = 8'd20; post_len = 4'd0; out_ready = 1'b0;
    tick(3);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", out_data, 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_triggered", 64'(triggered), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_drain_done", 64'(drain_done), 64'(0));
    rst = 1'b0;
    tick(1);

    // Manual trigger, no post-trigger records.
    do_arm();
    chk("t1_busy", 64'(busy), 64'(1));
    chk("t1_not_trig", 64'(triggered), 64'(0));
    for (int i = 0; i < 5; i++) send(16'h8000 + 16'(i), 1'b1);
    pulse_force();
    chk("t1_triggered", 64'(triggered), 64'(1));
    drain("t1", 4'b1111);
    chk("t1_overflow", 64'(overflow), 64'(0));

    // PC-match trigger with wraparound; record 13 arrives after post depth is used up.
    trig_mode = 2'd1; trig_pc = 16'hC123; post_len = 4'd2;
    do_arm();
    for (int i = 1; i <= 13; i++) send((i == 10) ? 16'hC123 : 16'hC000 + 16'(i), 1'b0);
    for (int i = 5; i <= 12; i++) sb.push_back(mkrec((i == 10) ? 16'hC123 : 16'hC000 + 16'(i)));
    chk("t2_triggered", 64'(triggered), 64'(1));
    chk("t2_overflow", 64'(overflow), 64'(1));
    drain("t2", 4'b1111);

    // Halt trigger needs 20 consecutive halted cycles.
    trig_mode = 2'd2; halt_cycles = 8'd20; post_len = 4'd0;
    do_arm();
    cpu_state = HALT_STATE;
    tick(19);
    cpu_state = ST_READ_OPCODE;
    tick(1);
    chk("t3_no_trig_run1", 64'(triggered), 64'(0));
    cpu_state = HALT_STATE;
    tick(19);
    chk("t3_no_trig_19", 64'(triggered), 64'(0));
    tick(1);
    chk("t3_trig_20", 64'(triggered), 64'(1));
    cpu_state = ST_READ_OPCODE;
    tick(1);
    chk("t3_empty_no_valid", 64'(out_valid), 64'(0));
    chk("t3_empty_no_done_yet", 64'(drain_done), 64'(0));
    tick(1);
    chk("t3_empty_drain_done", 64'(drain_done), 64'(1));
    chk("t3_empty_idle", 64'(busy), 64'(0));
    tick(1);
    chk("t3_done_one_pulse", 64'(drain_done), 64'(0));

    // Back-pressured drain.
    trig_mode = 2'd0;
    do_arm();
    for (int i = 0; i < 6; i++) send(16'h9000 + 16'(i), 1'b1);
    pulse_force();
    drain("t4", 4'b1001);

    // Abort in POST keeps overflow; the next arm clears it.
    post_len = 4'd5;
    do_arm();
    for (int i = 0; i < 9; i++) send(16'hA000 + 16'(i), 1'b0);
    pulse_force();
    chk("t5_post_trig", 64'(triggered), 64'(1));
    chk("t5_post_ovf", 64'(overflow), 64'(1));
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t5_abort_idle", 64'(busy), 64'(0));
    chk("t5_abort_trig", 64'(triggered), 64'(0));
    chk("t5_abort_valid", 64'(out_valid), 64'(0));
    chk("t5_abort_keeps_ovf", 64'(overflow), 64'(1));
    dd_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dd_seen |= drain_done;
      tick(1);
    end
    chk("t5_abort_no_done", 64'(dd_seen), 64'(0));
    do_arm();
    chk("t5_arm_clears_ovf", 64'(overflow), 64'(0));

    // Abort mid-drain after one record has been accepted.
    post_len = 4'd0;
    for (int i = 0; i < 4; i++) send(16'hB000 + 16'(i), 1'b0);
    pulse_force();
    out_ready = 1'b1;
    n = 0;
    while (!out_valid && n < 10) begin
      tick(1);
      n++;
    end
    chk("t5_drain_started", 64'(out_valid), 64'(1));
    chk("t5_first_rec", out_data, mkrec(16'hB000));
    tick(1);
    out_ready = 1'b0;
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t5_mid_abort_valid", 64'(out_valid), 64'(0));
    chk("t5_mid_abort_idle", 64'(busy), 64'(0));
    dd_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      dd_seen |= drain_done;
      dd_seen |= out_valid;
      tick(1);
    end
    chk("t5_mid_abort_quiet", 64'(dd_seen), 64'(0));

    // Reset during capture with rec_valid high.
    do_arm();
    rec_data  = mkrec(16'hD000);
    rec_valid = 1'b1;
    tick(2);
    rst = 1'b1;
    tick(1);
    chk("t6_rst_valid", 64'(out_valid), 64'(0));
    chk("t6_rst_data", out_data, 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_trig", 64'(triggered), 64'(0));
    chk("t6_rst_ovf", 64'(overflow), 64'(0));
    chk("t6_rst_done", 64'(drain_done), 64'(0));
    rst = 1'b0;
    rec_valid = 1'b0;
    tick(1);
    do_arm();
    for (int i = 0; i < 3; i++) send(16'hE000 + 16'(i), 1'b1);
    pulse_force();
    drain("t6", 4'b1111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_trace_buffer.md
Name: cpu_trace_buffer

Overview:
- Synthesizable on-chip CPU instruction trace capture, the hardware counterpart of the bench's opcode-fetch trace.
- Records one entry per opcode fetch: PC, opcode, A, X, Y, P and SP.
- Stores entries in a circular buffer and stops on a programmable trigger (manual, PC match, or CPU halt state held for a set number of cycles), with configurable post-trigger depth.
- Drains the frozen buffer oldest-first over a valid/ready stream. Sits beside NESMain's CPU, clocked by the master clock.

Parameters:
- DEPTH, 1024, entries in buffer; power of two, >= 4.
- REC_W, 64, record width: {pc[15:0], opcode, a, x, y, p, sp}.
- HALT_STATE, 8'h7F, CPU state encoding treated as halted.
- HALT_W, 8, width of the halt_cycles threshold.

Ports:
- clkMaster  in  1  master clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- rec_valid  in  1  one-cycle pulse per opcode fetch; the caller qualifies it with the phi0 edge.
- rec_data  in  REC_W  record; pc in bits [63:48].
- cpu_state  in  8  live CPU state, used for halt detection.
- arm  in  1  pulse: start a capture.
- abort  in  1  pulse: return to IDLE from any state.
- trig_force  in  1  pulse: manual trigger.
- trig_mode  in  2  0 manual only, 1 PC match, 2 halt, 3 PC match or halt (manual always active).
- trig_pc  in  16  PC match value.
- halt_cycles  in  HALT_W  consecutive halted cycles required.
- post_len  in  $clog2(DEPTH)+1  records captured after the trigger; values > DEPTH are clamped to DEPTH.
- out_valid  out  1  stream valid.
- out_data  out  REC_W  stream data.
- out_ready  in  1  stream ready.
- busy  out  1  state != IDLE.
- triggered  out  1  high in POST and DONE.
- overflow  out  1  sticky: oldest entry was overwritten during this capture.
- drain_done  out  1  one-cycle pulse when the last record is accepted.

Behaviour:
- Reset values: all outputs 0, state IDLE, pointers 0, count 0, halt counter 0.
- States and transitions:
  - IDLE: on arm, go to ARMED and clear count, wr_ptr and overflow.
  - ARMED: write every rec_valid at wr_ptr, then wr_ptr++ (wraps mod DEPTH).
    - count saturates at DEPTH; a write while count==DEPTH sets overflow.
    - On trigger: load post_rem = post_len and go to POST.
  - POST: each write decrements post_rem. When post_rem reaches 0 (including post_len==0 at entry), go to DONE on the next edge. Records arriving after that are dropped.
  - DONE: rd_ptr = wr_ptr - count (mod DEPTH).
    - Stream count records oldest-first.
    - When the last is accepted: pulse drain_done, go to IDLE.
- Trigger conditions, evaluated every cycle in ARMED only:
  - trig_force.
  - PC match: rec_valid && rec_data[63:48]==trig_pc, when the mode allows.
  - Halt: halt counter >= halt_cycles, when the mode allows.
- Trigger on a rec_valid cycle: that record is written and counts as pre-trigger, so it does not decrement post_rem.
- Halt counter: increments while cpu_state==HALT_STATE, saturating at its maximum; clears to 0 on any other state. It runs in all states, but only ARMED acts on it. halt_cycles==0 means the halt trigger fires on the first armed cycle.
- Readout:
  - The RAM read is synchronous with 1-cycle latency. The output register/skid stage holds out_data stable while out_valid && !out_ready.
  - First out_valid within 2 cycles of entering DONE.
  - Sustains 1 record/cycle with out_ready held high.
- count==0 on entering DONE: no out_valid; drain_done pulses 1 cycle after entry, then IDLE.
- Simultaneous events:
  - abort beats everything, in any state: next state IDLE, out_valid drops next cycle, no drain_done, overflow retained.
  - arm is ignored outside IDLE.
  - A trigger in the same cycle as the write that fills the buffer sets overflow only if count was already DEPTH.
- rst mid-operation: identical to the reset values; buffer contents are don't-care.
- Arithmetic: pointers are $clog2(DEPTH) bits and wrap naturally; count is $clog2(DEPTH)+1 bits.

Decomposition:
- Package cpu_trace_pkg:
  - trace_rec_t packed struct (pc, opcode, a, x, y, p, sp).
  - trig_mode_e enum.
  - trace_state_e {IDLE, ARMED, POST, DONE}.
  - ST_READ_OPCODE = 2 and HALT_STATE = 8'h7F constants, shared with benches.
- Sub-module trace_ram: simple dual-port DEPTH x REC_W, with a write port and a registered read port, inferable as block RAM.
- FSM, pointers, trigger and skid logic live in cpu_trace_buffer.

Test Plan:
1. DEPTH=8; arm; 5 records with pc 0x8000..0x8004; trig_force; post_len=0 -> DONE, stream pc 0x8000..0x8004, drain_done, overflow=0.
2. DEPTH=8, mode 1, trig_pc=0xC123, post_len=2; 12 records, match at record 10 -> stream records 5..12 (8 entries, last two post-trigger), overflow=1.
3. Mode 2, halt_cycles=20; cpu_state=0x7F for 19 cycles, then 0x02, then 0x7F for 20 cycles -> no trigger after the first run; trigger on the 20th cycle of the second run.
4. Drain with out_ready toggling 1,0,0,1 -> out_data stable while stalled, no duplicated or lost records, order preserved.
5. abort in POST and again mid-drain -> IDLE next cycle, out_valid=0, no drain_done; a following arm clears overflow.
6. rst asserted during ARMED with rec_valid high -> all outputs 0; a subsequent arm and 3 records followed by trig_force -> exactly 3 records streamed.
